div_seq: RTL and testbench

//  Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. Owns no subtractor:

---
 rtl/div_seq.sv | 193 +++++++++++++++++++
 tb/tb_div_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | div_seq : iterative radix-2 restoring divider (DIV/DIVU/REM/REMU) that      |
// |           borrows the shared exe-stage adder. Option: DIV_EARLY_EXIT_EN.    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+

`ifndef ALU_ADD
`define ALU_ADD 4'h0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'h1
`endif

module div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_start_i,
  input  logic            div_kill_i,
  input  logic [1:0]      div_op_i,
  input  logic [XLEN-1:0] div_opa_i,
  input  logic [XLEN-1:0] div_opb_i,
  output logic            div_busy_o,
  output logic            div_own_o,
  output logic [3:0]      adder_op_o,
  output logic [XLEN-1:0] adder_opa_o,
  output logic [XLEN-1:0] adder_opb_o,
  input  logic [XLEN-1:0] adder_out_i,
  input  logic            adder_c_i,
  output logic            div_valid_o,
  output logic [XLEN-1:0] div_result_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_CALC  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            busy_q, busy_d;
  logic            own_q, own_d;
  logic            valid_q, valid_d;

  logic            is_signed;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] trial;
  logic            accept;
  logic            div_zero;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  // In PREP the quotient register still holds the raw dividend and dvs the raw divisor.
  assign is_signed = ~op_q[0];
  assign sign_a    = is_signed & quo_q[XLEN-1];
  assign sign_b    = is_signed & dvs_q[XLEN-1];
  assign abs_a     = sign_a ? -quo_q : quo_q;
  assign abs_b     = sign_b ? -dvs_q : dvs_q;

  assign trial     = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
  assign accept    = rem_q[XLEN-1] | adder_c_i;

  // A zero divisor leaves rem == |a|, so re-applying the dividend sign restores a.
  assign div_zero  = (dvs_q == '0);
  assign quo_fix   = div_zero ? '1 : (negq_q ? -quo_q : quo_q);
  assign rem_fix   = negr_q ? -rem_q : rem_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;

    case (state_q)
      S_IDLE: begin
        if (div_start_i) begin
          op_d    = div_op_i;
          quo_d   = div_opa_i;
          dvs_d   = div_opb_i;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        quo_d   = abs_a;
        dvs_d   = abs_b;
        negq_d  = sign_a ^ sign_b;
        negr_d  = sign_a;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_CALC;
`ifdef DIV_EARLY_EXIT_EN
        if ((abs_b == '0) || (abs_a < abs_b)) begin
          quo_d   = '0;
          rem_d   = abs_a;
          state_d = S_FIXUP;
        end
`endif
      end
      S_CALC: begin
        rem_d = accept ? adder_out_i : trial;
        quo_d = {quo_q[XLEN-2:0], accept};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        result_d = op_q[1] ? rem_fix : quo_fix;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (div_kill_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end

    busy_d  = (state_d != S_IDLE);
    own_d   = (state_d == S_CALC);
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy_q   <= 1'b0;
      own_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      busy_q   <= busy_d;
      own_q    <= own_d;
      valid_q  <= valid_d;
    end
  end

  assign div_busy_o   = busy_q;
  assign div_own_o    = own_q;
  assign div_valid_o  = valid_q;
  assign div_result_o = result_q;
  assign adder_op_o   = own_q ? `ALU_SUB : `ALU_ADD;
  assign adder_opa_o  = trial;
  assign adder_opb_o  = dvs_q;

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_div_seq : directed + random scoreboard bench for div_seq with a shared   |
// |              adder model driven from the divider's adder ports.             |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+

`ifndef ALU_ADD
`define ALU_ADD 4'h0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'h1
`endif

module tb_div_seq;

  localparam logic [3:0] OP_ADD = `ALU_ADD;
  localparam logic [3:0] OP_SUB = `ALU_SUB;
  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        div_start_i;
  logic        div_kill_i;
  logic [1:0]  div_op_i;
  logic [31:0] div_opa_i;
  logic [31:0] div_opb_i;
  logic        div_busy_o;
  logic        div_own_o;
  logic [3:0]  adder_op_o;
  logic [31:0] adder_opa_o;
  logic [31:0] adder_opb_o;
  logic [31:0] adder_out_i;
  logic        adder_c_i;
  logic        div_valid_o;
  logic [31:0] div_result_o;

  div_seq #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .div_start_i  (div_start_i),
    .div_kill_i   (div_kill_i),
    .div_op_i     (div_op_i),
    .div_opa_i    (div_opa_i),
    .div_opb_i    (div_opb_i),
    .div_busy_o   (div_busy_o),
    .div_own_o    (div_own_o),
    .adder_op_o   (adder_op_o),
    .adder_opa_o  (adder_opa_o),
    .adder_opb_o  (adder_opb_o),
    .adder_out_i  (adder_out_i),
    .adder_c_i    (adder_c_i),
    .div_valid_o  (div_valid_o),
    .div_result_o (div_result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared exe-stage adder: carry out of a + ~b + 1 means no borrow.
  always_comb begin
    if (adder_op_o == OP_SUB) begin
      {adder_c_i, adder_out_i} = {1'b0, adder_opa_o} + {1'b0, ~adder_opb_o} + 33'd1;
    end else begin
      {adder_c_i, adder_out_i} = {1'b0, adder_opa_o} + {1'b0, adder_opb_o};
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int unsigned at;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          op_id = 0;
  int          own_run = 0;
  int          last_run = 0;
  logic [31:0] last_res = '0;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int unsigned lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_EXIT_EN
    begin
      logic [31:0] ma;
      logic [31:0] mb;
      ma = (!op[0] && a[31]) ? -a : a;
      mb = (!op[0] && b[31]) ? -b : b;
      if (mb == 32'd0 || ma < mb) return 3;
    end
`else
    if (op == 2'b00 && a == 32'd0 && b == 32'd0) return 35;
`endif
    return 35;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and run the output monitor / scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (div_own_o) begin
      own_run++;
    end else if (own_run != 0) begin
      last_run = own_run;
      own_run  = 0;
    end
    chk("adder_op", {28'd0, adder_op_o}, {28'd0, (div_own_o ? OP_SUB : OP_ADD)});
    if (div_valid_o) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("result#%0d", e.id), div_result_o, e.res);
        chk($sformatf("latency#%0d", e.id), cyc, e.at);
        last_res = e.res;
      end
    end
  endtask

  task automatic push_exp(input logic [31:0] res, input int unsigned at);
    exp_t e;
    e.res = res;
    e.at  = at;
    e.id  = op_id;
    op_id++;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    chk("outstanding", sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    div_op_i    = op;
    div_opa_i   = a;
    div_opb_i   = b;
    div_start_i = 1'b1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    drive(op, a, b);
    push_exp(exp, cyc + lat(op, a, b));
    tick();
    div_start_i = 1'b0;
    wait_done();
    tick();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"},   {31'd0, div_busy_o},  32'd0);
    chk({tag, "_own"},    {31'd0, div_own_o},   32'd0);
    chk({tag, "_valid"},  {31'd0, div_valid_o}, 32'd0);
    chk({tag, "_result"}, div_result_o,         32'd0);
    chk({tag, "_opa"},    adder_opa_o,          32'd0);
    chk({tag, "_opb"},    adder_opb_o,          32'd0);
    chk({tag, "_aop"},    {28'd0, adder_op_o},  {28'd0, OP_ADD});
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n       = 1'b0;
    div_start_i = 1'b0;
    div_kill_i  = 1'b0;
    div_op_i    = 2'b00;
    div_opa_i   = '0;
    div_opb_i   = '0;
    repeat (3) tick();
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    tick();

    run_op(DIVU, 32'd100, 32'd7, 32'd14);
    chk("own_cycles", last_run, 32'd32);
    run_op(REMU, 32'd100, 32'd7, 32'd2);
    run_op(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op(REM,  32'd7, 32'hFFFF_FFFE, 32'd1);
    run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op(REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    run_op(DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    run_op(DIVU, 32'd3, 32'd10, 32'd0);
    run_op(REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
    run_op(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(3, 0));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(31, 0);
      run_op(rop, ra, rb, model(rop, ra, rb));
    end

    // Kill mid-operation: no valid, result held, next start completes.
    drive(DIVU, 32'd1000, 32'd3);
    tick();
    div_start_i = 1'b0;
    chk("kill_busy_before", {31'd0, div_busy_o}, 32'd1);
    repeat (9) tick();
    div_kill_i = 1'b1;
    tick();
    div_kill_i = 1'b0;
    chk("kill_busy_after", {31'd0, div_busy_o}, 32'd0);
    chk("kill_valid", {31'd0, div_valid_o}, 32'd0);
    chk("kill_result_held", div_result_o, last_res);
    tick();
    run_op(DIVU, 32'd1000, 32'd3, 32'd333);

    // Kill and start together: kill wins.
    drive(DIVU, 32'd9, 32'd2);
    div_kill_i = 1'b1;
    tick();
    div_start_i = 1'b0;
    div_kill_i  = 1'b0;
    chk("kill_beats_start", {31'd0, div_busy_o}, 32'd0);
    tick();

    // Start held high: start during DONE ignored, next accepted one cycle later.
    drive(DIVU, 32'd100, 32'd7);
    push_exp(32'd14, cyc + 35);
    push_exp(32'd14, cyc + 71);
    repeat (37) tick();
    div_start_i = 1'b0;
    wait_done();
    tick();

    // Asynchronous reset mid-operation.
    drive(DIV, 32'd12345, 32'd67);
    tick();
    div_start_i = 1'b0;
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    last_res = '0;
    tick();
    rst_n = 1'b1;
    tick();
    run_op(REMU, 32'd12345, 32'd67, model(REMU, 32'd12345, 32'd67));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
